// File: rtl/rename_reg_file_pkg.sv
// Shared defaults and types for the rename register file.
// Contents:
//   XLEN, NREG, AW, TAG_W, NREAD : default geometry
//   word_t, reg_idx_t, rob_tag_t : default-width data / index / tag types
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int AW    = $clog2(NREG);
    localparam int TAG_W = 4;
    localparam int NREAD = 2;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [AW-1:0]    reg_idx_t;
    typedef logic [TAG_W-1:0] rob_tag_t;

endpackage

// File: rtl/rename_reg_file_if.sv
// Decode / issue / commit bus of the rename register file.
// Handshake semantics: there is no back-pressure. rdy_in is a global
// advance enable: while it is high every *_valid_in / flush_in is consumed
// at the rising clock edge; while it is low all inputs are ignored and all
// state and read outputs hold.
// Modports:
//   master : core side, drives requests, receives read results
//   slave  : register file side
interface rename_reg_file_if #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int AW    = regfile_pkg::AW,
    parameter int NREAD = regfile_pkg::NREAD,
    parameter int TAG_W = regfile_pkg::TAG_W
);
    logic                   rdy_in;
    logic [NREAD-1:0]       rd_valid_in;
    logic [NREAD*AW-1:0]    rd_addr_in;
    logic [NREAD*XLEN-1:0]  rd_data_out;
    logic [NREAD-1:0]       rd_busy_out;
    logic [NREAD*TAG_W-1:0] rd_tag_out;
    logic                   iss_valid_in;
    logic [AW-1:0]          iss_rd_in;
    logic [TAG_W-1:0]       iss_tag_in;
    logic                   cmt_valid_in;
    logic [AW-1:0]          cmt_rd_in;
    logic [TAG_W-1:0]       cmt_tag_in;
    logic [XLEN-1:0]        cmt_data_in;
    logic                   flush_in;

    modport master (
        output rdy_in, rd_valid_in, rd_addr_in,
        output iss_valid_in, iss_rd_in, iss_tag_in,
        output cmt_valid_in, cmt_rd_in, cmt_tag_in, cmt_data_in, flush_in,
        input  rd_data_out, rd_busy_out, rd_tag_out
    );

    modport slave (
        input  rdy_in, rd_valid_in, rd_addr_in,
        input  iss_valid_in, iss_rd_in, iss_tag_in,
        input  cmt_valid_in, cmt_rd_in, cmt_tag_in, cmt_data_in, flush_in,
        output rd_data_out, rd_busy_out, rd_tag_out
    );
endinterface

// File: rtl/rename_reg_file_read_port.sv
// One read port: takes the pre-update register state for its address,
// applies flush masking (and commit forwarding when REGFILE_BYPASS_EN is
// defined) and registers the result.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   en                         : capture enable (global ready & port valid)
//   addr                       : register index being read
//   data_raw/busy_raw/tag_raw  : register state at addr before this edge
//   cmt_*                      : same-cycle commit (used for forwarding)
//   flush                      : same-cycle flush, forces busy low
//   data/busy/tag              : registered read result
module regfile_read_port #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int AW    = regfile_pkg::AW,
    parameter int TAG_W = regfile_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [XLEN-1:0]  data_raw,
    input  logic             busy_raw,
    input  logic [TAG_W-1:0] tag_raw,
    input  logic             cmt_valid,
    input  logic [AW-1:0]    cmt_rd,
    input  logic [TAG_W-1:0] cmt_tag,
    input  logic [XLEN-1:0]  cmt_data,
    input  logic             flush,
    output logic [XLEN-1:0]  data,
    output logic             busy,
    output logic [TAG_W-1:0] tag
);
    import regfile_pkg::*;

    logic [XLEN-1:0]  data_nxt;
    logic             busy_nxt;
    logic [TAG_W-1:0] tag_nxt;

`ifdef REGFILE_BYPASS_EN
    logic unused_addr_ok;
    assign unused_addr_ok = 1'b0;
`else
    // Without forwarding the commit bus is seen by the consumer on the CDB.
    logic unused_cmt;
    assign unused_cmt = ^{cmt_valid, cmt_rd, cmt_tag, cmt_data, addr};
`endif

    always_comb begin
        data_nxt = data_raw;
        busy_nxt = busy_raw;
        tag_nxt  = tag_raw;
`ifdef REGFILE_BYPASS_EN
        // Forward a same-cycle commit; busy drops only for the latest producer.
        if (cmt_valid && (cmt_rd == addr) && (addr != '0)) begin
            data_nxt = cmt_data;
            if (tag_raw == cmt_tag) busy_nxt = 1'b0;
        end
`endif
        if (flush) busy_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            busy <= 1'b0;
            tag  <= '0;
        end else if (en) begin
            data <= data_nxt;
            busy <= busy_nxt;
            tag  <= tag_nxt;
        end
    end
endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tracking.
// Holds data/busy/tag per register; issue marks a register busy with its
// ROB tag, commit writes data and clears busy only for the latest producer,
// flush clears all rename state. Reads have one cycle latency and observe
// the state before the same-cycle issue/commit.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle commit
// to the read ports.
// Ports:
//   clk_in   : clock, all state on rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : rename_reg_file_if.slave (reads, issue, commit, flush, rdy)
module rename_reg_file #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREG  = regfile_pkg::NREG,
    parameter int NREAD = regfile_pkg::NREAD,
    parameter int TAG_W = regfile_pkg::TAG_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    rename_reg_file_if.slave bus
);
    import regfile_pkg::*;

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  data_q [NREG];
    logic [NREG-1:0]  busy_q;
    logic [TAG_W-1:0] tag_q  [NREG];

    // Register 0 is hardwired: writes and renames to it are dropped.
    logic cmt_hit;
    logic iss_hit;
    assign cmt_hit = bus.cmt_valid_in && (bus.cmt_rd_in != '0);
    assign iss_hit = bus.iss_valid_in && (bus.iss_rd_in != '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (bus.rdy_in) begin
            if (cmt_hit) begin
                data_q[bus.cmt_rd_in] <= bus.cmt_data_in;
                // A stale commit (older tag) must not clear a newer rename.
                if (tag_q[bus.cmt_rd_in] == bus.cmt_tag_in)
                    busy_q[bus.cmt_rd_in] <= 1'b0;
            end
            // Later assignments win: flush beats issue, issue beats commit.
            if (bus.flush_in) begin
                busy_q <= '0;
                for (int i = 0; i < NREG; i++) tag_q[i] <= '0;
            end else if (iss_hit) begin
                busy_q[bus.iss_rd_in] <= 1'b1;
                tag_q[bus.iss_rd_in]  <= bus.iss_tag_in;
            end
        end
    end

    logic [XLEN-1:0]  port_data [NREAD];
    logic             port_busy [NREAD];
    logic [TAG_W-1:0] port_tag  [NREAD];

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0] addr;
        assign addr = bus.rd_addr_in[p*AW +: AW];

        regfile_read_port #(
            .XLEN (XLEN),
            .AW   (AW),
            .TAG_W(TAG_W)
        ) u_port (
            .clk      (clk_in),
            .rst_n    (rst_n_in),
            .en       (bus.rdy_in & bus.rd_valid_in[p]),
            .addr     (addr),
            .data_raw (data_q[addr]),
            .busy_raw (busy_q[addr]),
            .tag_raw  (tag_q[addr]),
            .cmt_valid(bus.cmt_valid_in),
            .cmt_rd   (bus.cmt_rd_in),
            .cmt_tag  (bus.cmt_tag_in),
            .cmt_data (bus.cmt_data_in),
            .flush    (bus.flush_in),
            .data     (port_data[p]),
            .busy     (port_busy[p]),
            .tag      (port_tag[p])
        );
    end

    always_comb begin
        bus.rd_data_out = '0;
        bus.rd_busy_out = '0;
        bus.rd_tag_out  = '0;
        for (int p = 0; p < NREAD; p++) begin
            bus.rd_data_out[p*XLEN +: XLEN]  = port_data[p];
            bus.rd_busy_out[p]               = port_busy[p];
            bus.rd_tag_out[p*TAG_W +: TAG_W] = port_tag[p];
        end
    end
endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file. A behavioural model of the
// register state computes each read result when stimulus is driven and
// pushes it to exp_q; the DUT outputs sampled after the edge go to obs_q
// and each scenario task pops and compares both queues.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_rename_reg_file;
    import regfile_pkg::*;

    localparam int NRD = 2;
    localparam int EW  = XLEN + 1 + TAG_W;

    logic clk_in = 1'b0;
    logic rst_n_in;
    always #5 clk_in = ~clk_in;

    rename_reg_file_if #(.XLEN(XLEN), .AW(AW), .NREAD(NRD), .TAG_W(TAG_W)) bus ();

    rename_reg_file #(.XLEN(XLEN), .NREG(NREG), .NREAD(NRD), .TAG_W(TAG_W)) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] obs_q [$];

    word_t         m_data [NREG];
    logic          m_busy [NREG];
    rob_tag_t      m_tag  [NREG];
    logic [EW-1:0] last_exp [NRD];

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        for (int p = 0; p < NRD; p++) last_exp[p] = '0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // One clock of stimulus: model predicts, DUT is clocked, outputs recorded.
    task automatic drive_cycle(input logic rdy, input logic [1:0] rv,
                               input reg_idx_t a0, input reg_idx_t a1,
                               input logic iv, input reg_idx_t ird, input rob_tag_t itag,
                               input logic cv, input reg_idx_t crd, input rob_tag_t ctag,
                               input word_t cdata, input logic fl);
        reg_idx_t a;
        word_t    d;
        logic     b;
        rob_tag_t t;
        bus.rdy_in       = rdy;
        bus.rd_valid_in  = rv;
        bus.rd_addr_in   = {a1, a0};
        bus.iss_valid_in = iv;
        bus.iss_rd_in    = ird;
        bus.iss_tag_in   = itag;
        bus.cmt_valid_in = cv;
        bus.cmt_rd_in    = crd;
        bus.cmt_tag_in   = ctag;
        bus.cmt_data_in  = cdata;
        bus.flush_in     = fl;
        for (int p = 0; p < NRD; p++) begin
            a = (p == 0) ? a0 : a1;
            if (rdy && rv[p]) begin
                d = m_data[a];
                b = m_busy[a];
                t = m_tag[a];
`ifdef REGFILE_BYPASS_EN
                if (cv && crd == a && a != 0) begin
                    d = cdata;
                    if (m_tag[a] == ctag) b = 1'b0;
                end
`endif
                if (fl) b = 1'b0;
                last_exp[p] = {d, b, t};
            end
            exp_q.push_back(last_exp[p]);
        end
        if (rdy) begin
            if (cv && crd != 0) begin
                m_data[crd] = cdata;
                if (m_tag[crd] == ctag) m_busy[crd] = 1'b0;
            end
            if (fl) begin
                for (int i = 0; i < NREG; i++) begin
                    m_busy[i] = 1'b0;
                    m_tag[i]  = '0;
                end
            end else if (iv && ird != 0) begin
                m_busy[ird] = 1'b1;
                m_tag[ird]  = itag;
            end
        end
        @(posedge clk_in);
        #1;
        for (int p = 0; p < NRD; p++)
            obs_q.push_back({bus.rd_data_out[p*XLEN +: XLEN], bus.rd_busy_out[p],
                             bus.rd_tag_out[p*TAG_W +: TAG_W]});
    endtask

    task automatic do_issue(input reg_idx_t rd, input rob_tag_t tg);
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b1, rd, tg, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_commit(input reg_idx_t rd, input rob_tag_t tg, input word_t d);
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b0, 0, 0, 1'b1, rd, tg, d, 1'b0);
    endtask

    task automatic do_read(input reg_idx_t a0, input reg_idx_t a1);
        drive_cycle(1'b1, 2'b11, a0, a1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    // Tag is only meaningful while busy, so it is masked otherwise.
    function automatic logic [EW-1:0] cmp_mask(input logic [EW-1:0] e);
        return e[TAG_W] ? {EW{1'b1}} : {{(XLEN+1){1'b1}}, {TAG_W{1'b0}}};
    endfunction

    task automatic test_reset();
        logic [EW-1:0] e, o, m;
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (bus.rd_data_out !== '0) begin failures++; $display("FAIL reset_data got=%h expected=0", bus.rd_data_out); end
        checks++;
        if (bus.rd_busy_out !== '0) begin failures++; $display("FAIL reset_busy got=%b expected=0", bus.rd_busy_out); end
        checks++;
        if (bus.rd_tag_out !== '0) begin failures++; $display("FAIL reset_tag got=%h expected=0", bus.rd_tag_out); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        do_issue(5, 3);
        do_read(5, 5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL pre_reset_read got=%h expected=%h", o, e); end
        end
        // Assert reset between clock edges; outputs must clear without a clock.
        #3 rst_n_in = 1'b0;
        #1;
        checks++;
        if (bus.rd_busy_out !== '0) begin failures++; $display("FAIL async_reset_busy got=%b expected=0", bus.rd_busy_out); end
        checks++;
        if (bus.rd_tag_out !== '0) begin failures++; $display("FAIL async_reset_tag got=%h expected=0", bus.rd_tag_out); end
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        do_read(5, 5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = {EW{1'b1}};
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL post_reset_read got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_commit();
        logic [EW-1:0] e, o, m;
        do_issue(5, 3);
        do_commit(5, 3, 32'hDEADBEEF);
        do_read(5, 5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL commit_clear got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_stale_commit();
        logic [EW-1:0] e, o, m;
        do_issue(5, 3);
        do_issue(5, 7);
        do_commit(5, 3, 32'h11);
        do_read(5, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL stale_commit got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_x0();
        logic [EW-1:0] e, o, m;
        do_issue(0, 2);
        do_commit(0, 2, 32'hFF);
        do_read(0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL reg_zero got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_same_cycle_read();
        logic [EW-1:0] e, o, m;
        drive_cycle(1'b1, 2'b11, 6, 6, 1'b1, 6, 4, 1'b0, 0, 0, 0, 1'b0);
        do_read(6, 6);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL issue_read_order got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_issue_commit_same();
        logic [EW-1:0] e, o, m;
        do_issue(8, 1);
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b1, 8, 5, 1'b1, 8, 1, 32'h55, 1'b0);
        do_read(8, 6);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL issue_beats_commit got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_stall();
        logic [EW-1:0] e, o, m;
        do_read(5, 6);
        drive_cycle(1'b0, 2'b11, 8, 9, 1'b1, 11, 6, 1'b1, 11, 6, 32'hAAAA, 1'b1);
        drive_cycle(1'b0, 2'b11, 1, 2, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        do_read(11, 5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL stall_hold got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_flush();
        logic [EW-1:0] e, o, m;
        drive_cycle(1'b1, 2'b11, 5, 8, 1'b1, 9, 2, 1'b1, 10, 0, 32'h1234, 1'b1);
        do_read(9, 10);
        do_read(5, 8);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL flush got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_bypass_flush();
        logic [EW-1:0] e, o, m;
        do_issue(7, 9);
        do_issue(3, 1);
        drive_cycle(1'b1, 2'b01, 7, 0, 1'b0, 0, 0, 1'b1, 7, 9, 32'h42, 1'b0);
        do_read(7, 3);
        do_issue(7, 2);
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
        do_read(7, 3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL bypass_flush got=%h expected=%h", o, e); end
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] e, o, m;
        for (int n = 0; n < 300; n++) begin
            drive_cycle($urandom_range(9, 0) != 0, 2'($urandom_range(3, 0)),
                        5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                        1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), 4'($urandom_range(3, 0)),
                        1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), 4'($urandom_range(3, 0)),
                        $urandom, $urandom_range(19, 0) == 0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); m = cmp_mask(e);
            checks++;
            if ((o & m) !== (e & m)) begin failures++; $display("FAIL random got=%h expected=%h", o, e); end
        end
    endtask

    initial begin
        bus.rdy_in       = 1'b0;
        bus.rd_valid_in  = '0;
        bus.rd_addr_in   = '0;
        bus.iss_valid_in = 1'b0;
        bus.iss_rd_in    = '0;
        bus.iss_tag_in   = '0;
        bus.cmt_valid_in = 1'b0;
        bus.cmt_rd_in    = '0;
        bus.cmt_tag_in   = '0;
        bus.cmt_data_in  = '0;
        bus.flush_in     = 1'b0;
        rst_n_in         = 1'b0;
        model_reset();
        test_reset();
        test_commit();
        test_stale_commit();
        test_x0();
        test_same_cycle_read();
        test_issue_commit_same();
        test_stall();
        test_flush();
        test_bypass_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
